// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit single-port memory between fetch (I) and load/store (D), turning word stores into dword read-modify-write
// Ports: clk, reset (async, active-high)
//   I side: i_req, i_addr -> i_rdata, i_ack
//   D side: d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack
//   memory: mem_we, mem_a, mem_wd (registered, sole driver), mem_rd (combinational read data)
module mem_port_arbiter #(
    parameter int AW = 64,
    parameter bit FAIR = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [63:0]   mem_wd,
    input  logic [63:0]   mem_rd
);
    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
    state_t state, state_nx;
    logic owner, we, sel_hi, last_grant, start, gnt_d, req_we, fin;
    logic [31:0] wdata;
    logic [AW-1:0] req_a;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        start = (state == IDLE) && (i_req || d_req);
        gnt_d = d_req && (!i_req || !FAIR || !last_grant);
        req_a = gnt_d ? d_addr : i_addr;
        req_we = gnt_d && d_we;
        fin = (state == RD && !we) || state == WR;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RD : IDLE;
            RD:      state_nx = we ? WR : ACK;
            WR:      state_nx = ACK;
            default: state_nx = IDLE;
        endcase
    end
    // mem_we and mem_a are registered so the memory sees glitch-free controls; stores address the whole dword
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            we         <= 1'b0;
            sel_hi     <= 1'b0;
            wdata      <= '0;
            last_grant <= 1'b1;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            i_ack  <= fin && !owner;
            d_ack  <= fin && owner;
            mem_we <= state == RD && we;
            if (start) begin
                owner      <= gnt_d;
                last_grant <= gnt_d;
                we         <= req_we;
                wdata      <= d_wdata;
                sel_hi     <= req_a[2];
                mem_a      <= req_a & ~AW'(req_we ? 3'd7 : 3'd3);
            end
            if (state == RD && we) mem_wd <= sel_hi ? {wdata, mem_rd[31:0]} : {mem_rd[63:32], wdata};
            if (state == RD && !we && owner) d_rdata <= mem_rd[31:0];
            if (state == RD && !we && !owner) i_rdata <= mem_rd[31:0];
        end
    end
endmodule
